instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 16-bit core. Sequences fetch, decode, execute, memory and writeback.
//  Drives IR/PC/regfile write enables and a single shared memory port with a req/ack handshake.
//  Consumes the combinational decoder outputs and the branch comparator result.
//  Sits between the decoder/comparator and the PC, IR, register file and memory mux.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles a memory request may wait for ack; 0 disables the timeout
//  CNT_W        4   width of the timeout counter; must hold MEM_TIMEOUT
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst_n          in   1   reset, synchronous, active-low
//  run            in   1   1 = execute instructions; 0 = stop at the next instruction boundary
//  instr_class    in   2   IR[15:14]: 00 mem, 01 alu, 10 jump, 11 illegal
//  jmp_cond       in   3   IR[13:11]: 111 NOP, 110 unconditional, other = conditional
//  dec_mem_read   in   1   decoder: load
//  dec_mem_write  in   1   decoder: store
//  dec_reg_write  in   1   decoder: register write requested
//  cmp_taken      in   1   comparator result for the current jump
//  mem_ack        in   1   memory completes the request this cycle
//  mem_req        out  1   memory request, held high until ack
//  mem_we         out  1   1 = write access (valid while mem_req is high)
//  mem_addr_sel   out  1   0 = PC (fetch), 1 = ALU result (data)
//  ir_we          out  1   load IR from the memory read data
//  pc_we          out  1   update PC
//  pc_src         out  1   0 = PC+1, 1 = jump target (reg_dst value)
//  rf_we          out  1   register file write strobe
//  retired        out  1   one-cycle pulse when an instruction completes
//  busy           out  1   state != IDLE and state != FAULT
//  fault          out  1   sticky fault flag
//  fault_code     out  2   01 illegal opcode, 10 fetch timeout, 11 data timeout
//  retire_count   out  16  retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge) beats every other event, including one mid-access.
//    All outputs go to 0, state to IDLE, timeout counter to 0; mem_req drops on that edge.
//  - States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT. Outputs are Moore-registered except ir_we, which is ack-qualified.
//  - IDLE: run=1 -> FETCH.
//  - FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
//    On mem_ack: ir_we=1 in the same cycle, then -> DECODE.
//  - DECODE: 1 cycle. Class 11 -> FAULT with code 01. Otherwise -> EXEC.
//    Decoder inputs are valid from DECODE and must stay stable through WB.
//  - EXEC, class 00 -> MEM.
//  - EXEC, class 01 -> WB.
//  - EXEC, class 10 (retires here):
//    - pc_we=1 and retired=1.
//    - pc_src=1 if jmp_cond=110, or if jmp_cond!=111 and cmp_taken=1; else pc_src=0.
//  - MEM: mem_req=1, mem_addr_sel=1, mem_we=dec_mem_write.
//    On ack: load -> WB; store -> retire (pc_we=1, pc_src=0, retired=1).
//  - WB: rf_we=dec_reg_write, pc_we=1, pc_src=0, retired=1.
//  - After a retire: run=1 -> FETCH, else -> IDLE. run is ignored mid-instruction.
//  - Timeout: the counter clears on entry to FETCH/MEM and increments each non-ack cycle.
//    When count reaches MEM_TIMEOUT-1 with no ack -> FAULT with code 10 (FETCH) or 11 (MEM).
//    An ack in that same cycle wins.
//  - mem_ack is ignored whenever mem_req=0.
//  - FAULT: all strobes 0, fault=1, fault_code held; only reset exits.
//  - Latency from FETCH entry with a 0-wait-state memory (ack in the first request cycle):
//    alu = 4 cycles, load = 5, store = 4, jump = 3.
// CONFIGURATION
//  - SEQ_RETIRE_CNT_EN defined: retire_count increments on every retired pulse.
//    It saturates at 16'hFFFF and resets to 0.
//  - SEQ_RETIRE_CNT_EN undefined: retire_count is tied to 16'h0000 and no counter logic is built.
// TESTING
//  1. Reset held mid-FETCH (mem_req=1): release with run=0 -> all outputs 0, state IDLE, mem_req stays 0.
//  2. ALU op, ack in the first request cycle:
//     -> ir_we at cycle 0, rf_we=1/pc_we=1/retired=1 at cycle 3, mem_req again at cycle 4.
//  3. Load with ack after 3 wait cycles in MEM:
//     -> mem_addr_sel=1 and mem_we=0 for 4 cycles, then rf_we=1 in WB.
//  4. Store:
//     -> mem_we=1, retire on the ack cycle, rf_we never 1.
//  5. Jump, jmp_cond=011:
//     - cmp_taken=1 -> pc_src=1.
//     - cmp_taken=0 -> pc_src=0.
//     - jmp_cond=111 with cmp_taken=1 -> pc_src=0.
//  6. Faults:
//     - Class 11 -> fault=1, fault_code=01.
//     - Fetch with no ack and MEM_TIMEOUT=4 -> FAULT, code 10, after 4 request cycles.
//     - Ack on the 4th request cycle -> no fault.

Source files
------------

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control FSM for the 16-bit core. Sequences fetch, decode,
//   execute, memory and writeback. It drives the IR/PC/register-file write
//   enables and owns one shared memory port with a req/ack handshake.
//
//   Parameters
//     MEM_TIMEOUT  max cycles a memory request may wait for ack (0 = no limit)
//     CNT_W        width of the timeout counter (must hold MEM_TIMEOUT)
//
//   Ports
//     clk, rst_n          clock, synchronous active-low reset
//     run                 execute instructions / stop at instruction boundary
//     instr_class         IR[15:14]: 00 mem, 01 alu, 10 jump, 11 illegal
//     jmp_cond            IR[13:11]: 111 NOP, 110 unconditional, else cond.
//     dec_mem_read/write  decoder load/store flags
//     dec_reg_write       decoder register-write flag
//     cmp_taken           branch comparator result
//     mem_ack             memory completes the request this cycle
//     mem_req, mem_we,    memory request, write select,
//     mem_addr_sel        address source (0 PC, 1 ALU result)
//     ir_we, pc_we,       IR load, PC update,
//     pc_src, rf_we       PC source (0 PC+1, 1 target), register write
//     retired             one-cycle pulse per completed instruction
//     busy, fault,        activity flag, sticky fault flag,
//     fault_code          01 illegal, 10 fetch timeout, 11 data timeout
//     retire_count        retired-instruction count
//
//   Build option
//     SEQ_RETIRE_CNT_EN   when defined, retire_count is a saturating counter;
//                         otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [1:0]  instr_class,
    input  logic [2:0]  jmp_cond,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        cmp_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        rf_we,
    output logic        retired,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] retire_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_e;

    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fault_code_q, fault_code_d;

    logic mem_req_q,      mem_req_d;
    logic mem_we_q,       mem_we_d;
    logic mem_addr_sel_q, mem_addr_sel_d;
    logic pc_we_q,        pc_we_d;
    logic pc_src_q,       pc_src_d;
    logic rf_we_q,        rf_we_d;
    logic retired_q,      retired_d;
    logic busy_q,         busy_d;
    logic fault_q,        fault_d;

    logic timeout_hit;
    logic jump_taken;
    logic store_retire;

    // The load/store split is fully determined by class 00 plus dec_mem_write.
    logic unused_dec_mem_read;
    assign unused_dec_mem_read = dec_mem_read;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);
    assign jump_taken  = (jmp_cond == 3'b110) ||
                         ((jmp_cond != 3'b111) && cmp_taken);

    // Store completes on the ack cycle itself, so its retire strobes are
    // ack-qualified like ir_we rather than registered.
    assign store_retire = (state_q == S_MEM) && mem_ack && dec_mem_write;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fault_code_d = fault_code_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (instr_class == 2'b11) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (instr_class)
                    2'b00: begin
                        state_d = S_MEM;
                        cnt_d   = '0;
                    end
                    2'b01: state_d = S_WB;
                    2'b10: begin
                        state_d = run ? S_FETCH : S_IDLE;
                        cnt_d   = '0;
                    end
                    default: begin
                        state_d      = S_FAULT;
                        fault_code_d = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (dec_mem_write) begin
                        state_d = run ? S_FETCH : S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                state_d = run ? S_FETCH : S_IDLE;
                cnt_d   = '0;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase

        // Registered Moore outputs are computed from the next state; decoder
        // and comparator inputs are already stable when EXEC/MEM/WB is entered.
        mem_req_d      = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_addr_sel_d = (state_d == S_MEM);
        mem_we_d       = (state_d == S_MEM) && dec_mem_write;
        pc_we_d        = (state_d == S_WB) ||
                         ((state_d == S_EXEC) && (instr_class == 2'b10));
        retired_d      = pc_we_d;
        pc_src_d       = (state_d == S_EXEC) && (instr_class == 2'b10) && jump_taken;
        rf_we_d        = (state_d == S_WB) && dec_reg_write;
        busy_d         = (state_d != S_IDLE) && (state_d != S_FAULT);
        fault_d        = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            fault_code_q   <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_sel_q <= 1'b0;
            pc_we_q        <= 1'b0;
            pc_src_q       <= 1'b0;
            rf_we_q        <= 1'b0;
            retired_q      <= 1'b0;
            busy_q         <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fault_code_q   <= fault_code_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_sel_q <= mem_addr_sel_d;
            pc_we_q        <= pc_we_d;
            pc_src_q       <= pc_src_d;
            rf_we_q        <= rf_we_d;
            retired_q      <= retired_d;
            busy_q         <= busy_d;
            fault_q        <= fault_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr_sel = mem_addr_sel_q;
    assign ir_we        = (state_q == S_FETCH) && mem_ack;
    assign pc_we        = pc_we_q   | store_retire;
    assign retired      = retired_q | store_retire;
    assign pc_src       = pc_src_q;
    assign rf_we        = rf_we_q;
    assign busy         = busy_q;
    assign fault        = fault_q;
    assign fault_code   = fault_code_q;

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retire_count_q, retire_count_d;

    always_comb begin
        retire_count_d = retire_count_q;
        if (retired && (retire_count_q != 16'hFFFF)) begin
            retire_count_d = retire_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retire_count = retire_count_q;
`else
    assign retire_count = '0;
`endif

endmodule
